vhm_mem_arbiter: RTL and testbench

Shares the VHM's single memory port between the instruction-fetch path and the load/store unit. Accepts one request at a time from either requester, arbitrates round-robin, and sequences the downstream memory handshake. Returns the response to the owning requester. Also range-checks addresses against the 0x10000000-byte memory and bounds every access with a timeout, so a hung memory model cannot stall the core.

---
 rtl/vhm_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vhm_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vhm_mem_arbiter.sv
// vhm_mem_arbiter: shares one memory port between instruction fetch and the LSU.
// Round-robin arbitration, range check at acceptance, and a bounded wait so a
// hung memory model returns an error instead of stalling the core.
module vhm_mem_arbiter #(
    parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_1000_0000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    // load/store requester
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wstrb,
    output logic        lsu_rsp_valid,
    output logic [63:0] lsu_rsp_data,
    output logic        lsu_rsp_err,
    // downstream memory
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LSU} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, rr_last_q, resp_owner;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:2]        addr_q;
    logic               we_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wstrb_q;

    logic               grant_if, grant_lsu, accept, range_err;
    logic               to_resp, resp_ok;
    logic               if_oor, lsu_oor;
    logic [64:0]        if_last, lsu_last;

    // Last byte touched by each candidate must fall below the memory size
    always_comb begin
        if_last  = {1'b0, if_req_addr}  + 65'd3;
        lsu_last = {1'b0, lsu_req_addr} + 65'd7;
        if_oor   = (if_req_addr  >= ADDR_LIMIT) || (if_last  >= {1'b0, ADDR_LIMIT});
        lsu_oor  = (lsu_req_addr >= ADDR_LIMIT) || (lsu_last >= {1'b0, ADDR_LIMIT});
    end

    // Next-state, arbitration and timeout decisions
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_if      = 1'b0;
        grant_lsu     = 1'b0;
        accept        = 1'b0;
        range_err     = 1'b0;
        to_resp       = 1'b0;
        resp_ok       = 1'b0;
        if_req_ready  = 1'b0;
        lsu_req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_if      = if_req_valid && (!lsu_req_valid || rr_last_q == OWN_LSU);
                grant_lsu     = lsu_req_valid && !grant_if;
                if_req_ready  = grant_if && !rst;
                lsu_req_ready = grant_lsu && !rst;
                accept        = grant_if || grant_lsu;
                range_err     = grant_if ? if_oor : lsu_oor;
                if (accept) begin
                    if (range_err) begin
                        state_d = S_RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (state_q == S_WAIT && mem_rsp_valid) begin
                    state_d = S_RESP;
                    to_resp = 1'b1;
                    resp_ok = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    to_resp = 1'b1;
                end else if (state_q == S_ISSUE && mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        resp_owner = (state_q == S_IDLE) ? (grant_if ? OWN_IF : OWN_LSU) : owner_q;
    end

    // State and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture, memory request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q       <= OWN_IF;
            rr_last_q     <= OWN_LSU;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            mem_req_valid <= 1'b0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            if_rsp_err    <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            mem_req_valid <= (state_d == S_ISSUE);
            if (accept) begin
                owner_q   <= grant_if ? OWN_IF : OWN_LSU;
                rr_last_q <= grant_if ? OWN_IF : OWN_LSU;
                if (grant_if) begin
                    addr_q  <= if_req_addr[63:2];
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                end else begin
                    addr_q  <= lsu_req_addr[63:2];
                    we_q    <= lsu_req_we;
                    wdata_q <= lsu_req_wdata;
                    wstrb_q <= lsu_req_wstrb;
                end
            end
            if_rsp_valid  <= to_resp && (resp_owner == OWN_IF);
            lsu_rsp_valid <= to_resp && (resp_owner == OWN_LSU);
            if (to_resp && resp_owner == OWN_IF) begin
                if_rsp_err  <= !resp_ok;
                if_rsp_data <= !resp_ok ? 32'd0 :
                               (addr_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0]);
            end
            if (to_resp && resp_owner == OWN_LSU) begin
                lsu_rsp_err  <= !resp_ok;
                lsu_rsp_data <= resp_ok ? mem_rsp_data : 64'd0;
            end
        end
    end

    // Downstream request fields come straight from the captured registers
    always_comb begin
        mem_req_addr  = {addr_q[63:3], 3'b000};
        mem_req_we    = we_q;
        mem_req_wdata = wdata_q;
        mem_req_wstrb = wstrb_q;
    end

endmodule

// File: tb/tb_vhm_mem_arbiter.sv
// Bench for vhm_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, range and timeout rules.
module tb_vhm_mem_arbiter;

    localparam logic [63:0] LIMIT = 64'h0000_0000_1000_0000;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_req_addr;
    logic [31:0] if_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, lsu_rsp_err;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [7:0]  lsu_req_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [7:0]  mem_req_wstrb;

    always #5 clk = ~clk;

    vhm_mem_arbiter #(.ADDR_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pending requests per requester; rr_last: 0 = IF, 1 = LSU
    int          rr_last;
    bit          if_pend, lsu_pend;
    logic [63:0] if_a, lsu_a, lsu_wd;
    logic        lsu_we;
    logic [7:0]  lsu_ws;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; entered and left one step after a rising edge
    task automatic run_txn(input int d, input int r, input bit hang, input logic [63:0] rdata);
        int          win, exp_c, last, size;
        bit          oor, exp_err;
        logic [63:0] a, wd, exp_data;
        logic [64:0] last_byte;
        logic        we;
        logic [7:0]  ws;
        if_req_valid  = if_pend;  if_req_addr   = if_a;
        lsu_req_valid = lsu_pend; lsu_req_addr  = lsu_a;
        lsu_req_we    = lsu_we;   lsu_req_wdata = lsu_wd; lsu_req_wstrb = lsu_ws;
        mem_req_ready = 1'b0;     mem_rsp_valid = 1'b0;   mem_rsp_data  = rdata;
        #1;
        if (if_pend && lsu_pend) win = (rr_last == 0) ? 1 : 0;
        else                     win = if_pend ? 0 : 1;
        check("if_req_ready_grant", if_req_ready, win == 0);
        check("lsu_req_ready_grant", lsu_req_ready, win == 1);
        if (win == 0) begin
            a = if_a; we = 1'b0; wd = '0; ws = '0; size = 4; if_pend = 0;
        end else begin
            a = lsu_a; we = lsu_we; wd = lsu_wd; ws = lsu_ws; size = 8; lsu_pend = 0;
        end
        rr_last   = win;
        last_byte = {1'b0, a} + 65'(size - 1);
        oor       = !(last_byte < {1'b0, LIMIT});
        if (oor) begin
            exp_c = 1; exp_err = 1;
        end else if (!hang && d + r + 1 <= TMO) begin
            exp_c = d + r + 2; exp_err = 0;
        end else begin
            exp_c = TMO + 1; exp_err = 1;
        end
        if (exp_err)       exp_data = '0;
        else if (win == 1) exp_data = rdata;
        else               exp_data = a[2] ? {32'd0, rdata[63:32]} : {32'd0, rdata[31:0]};
        last = exp_c + (hang ? 3 : 0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (win == 0) if_req_valid = 1'b0; else lsu_req_valid = 1'b0;
            end
            if (c > exp_c) begin
                if_req_valid = 1'b0; lsu_req_valid = 1'b0;
            end
            mem_req_ready = !oor && (c == 1 + d);
            mem_rsp_valid = (!oor && c == 1) || (!oor && !hang && c == 1 + d + r) ||
                            (hang && c == exp_c + 2);
            #1;
            check("mem_req_valid", mem_req_valid, !oor && c <= 1 + d);
            if (!oor && c <= 1 + d) begin
                check("mem_req_addr", mem_req_addr, a & ~64'h7);
                check("mem_req_we", mem_req_we, we);
                check("mem_req_wdata", mem_req_wdata, wd);
                check("mem_req_wstrb", mem_req_wstrb, ws);
            end
            check("ready_busy", {if_req_ready, lsu_req_ready}, 0);
            check("if_rsp_valid", if_rsp_valid, c == exp_c && win == 0);
            check("lsu_rsp_valid", lsu_rsp_valid, c == exp_c && win == 1);
            if (c == exp_c && win == 0) begin
                check("if_rsp_data", if_rsp_data, exp_data);
                check("if_rsp_err", if_rsp_err, exp_err);
            end
            if (c == exp_c && win == 1) begin
                check("lsu_rsp_data", lsu_rsp_data, exp_data);
                check("lsu_rsp_err", lsu_rsp_err, exp_err);
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_addr(input bit is_if);
        logic [63:0] v;
        int          sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)      v = 64'($urandom_range(0, 32'h0FFF_FFFF));
        else if (sel < 9) v = LIMIT - 64'($urandom_range(1, 12));
        else              v = {$urandom, $urandom};
        if (is_if) v = v & ~64'h3;
        return v;
    endfunction

    task automatic fill_random();
        if (!if_pend && $urandom_range(0, 2) != 0) begin
            if_pend = 1; if_a = rand_addr(1'b1);
        end
        if (!lsu_pend && ($urandom_range(0, 2) != 0 || !if_pend)) begin
            lsu_pend = 1; lsu_a = rand_addr(1'b0);
            lsu_we = 1'($urandom_range(0, 1));
            lsu_wd = {$urandom, $urandom};
            lsu_ws = 8'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d, r;
        bit h;
        rst = 1'b1;
        if_req_valid = 0; if_req_addr = '0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_we = 0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        if_pend = 0; lsu_pend = 0; rr_last = 1;
        if_a = '0; lsu_a = '0; lsu_we = 0; lsu_wd = '0; lsu_ws = '0;
        repeat (3) @(posedge clk);
        #1;
        if_req_valid = 1; lsu_req_valid = 1;
        #1;
        check("rst_ready", {if_req_ready, lsu_req_ready}, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_rsp_valid", {if_rsp_valid, lsu_rsp_valid}, 0);
        check("rst_rsp_err", {if_rsp_err, lsu_rsp_err}, 0);
        check("rst_rsp_data", lsu_rsp_data ^ {32'd0, if_rsp_data}, 0);
        if_req_valid = 0; lsu_req_valid = 0; rst = 1'b0;
        @(posedge clk); #1;

        // Both valid after reset: IF first, then LSU at minimum latency
        if_pend = 1; if_a = 64'h4;
        lsu_pend = 1; lsu_a = 64'h40; lsu_we = 0; lsu_wd = '0; lsu_ws = 8'hFF;
        run_txn(0, 1, 0, 64'h1122334455667788);
        run_txn(0, 1, 0, 64'h1122334455667788);

        // Store with delayed memory ready
        lsu_pend = 1; lsu_a = 64'h100; lsu_we = 1; lsu_wd = 64'hDEAD_BEEF_0BAD_F00D; lsu_ws = 8'h0F;
        run_txn(3, 2, 0, 64'h0);

        // Range boundaries for both requesters
        if_pend = 1; if_a = 64'h0FFF_FFFC;
        run_txn(0, 1, 0, 64'hCAFE_0001_CAFE_0002);
        if_pend = 1; if_a = 64'h1000_0000;
        run_txn(0, 1, 0, 64'h1);
        lsu_pend = 1; lsu_a = 64'h0FFF_FFF8; lsu_we = 0;
        run_txn(1, 1, 0, 64'h0123_4567_89AB_CDEF);
        lsu_pend = 1; lsu_a = 64'h0FFF_FFFC;
        run_txn(0, 1, 0, 64'h1);

        // Memory never answers, then a stray response; then timeout edge cases
        lsu_pend = 1; lsu_a = 64'h200; lsu_we = 0;
        run_txn(1, 1, 1, 64'h5);
        lsu_pend = 1; lsu_a = 64'h208;
        run_txn(2, 13, 0, 64'h7777_8888_9999_AAAA);
        if_pend = 1; if_a = 64'h20C;
        run_txn(2, 14, 0, 64'h7777_8888_9999_AAAA);

        // Both held valid continuously: grants alternate
        for (int i = 0; i < 8; i++) begin
            if (!if_pend)  begin if_pend = 1;  if_a = 64'(i * 16); end
            if (!lsu_pend) begin lsu_pend = 1; lsu_a = 64'(i * 16 + 8); lsu_we = 0; end
            run_txn(0, 1, 0, {$urandom, $urandom});
        end
        if_pend = 0; lsu_pend = 0;

        // Reset while waiting on memory aborts silently
        if_req_valid = 1; if_req_addr = 64'h300; lsu_req_valid = 0;
        #1;
        check("rstw_grant", if_req_ready, 1);
        @(posedge clk); #1;
        if_req_valid = 0; mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0; rst = 1;
        #1;
        check("rstw_rsp_valid", {if_rsp_valid, lsu_rsp_valid}, 0);
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("rstw_mem_valid", mem_req_valid, 0);
        check("rstw_mem_addr", mem_req_addr, 0);
        check("rstw_rsp_valid2", {if_rsp_valid, lsu_rsp_valid}, 0);
        check("rstw_rsp_fields", {if_rsp_err, lsu_rsp_err, if_rsp_data}, 0);
        rr_last = 1;
        if_pend = 1; if_a = 64'h304;
        run_txn(1, 2, 0, 64'hA1A2_A3A4_B1B2_B3B4);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            fill_random();
            d = $urandom_range(0, 3);
            r = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 14) : $urandom_range(1, 3);
            h = ($urandom_range(0, 9) == 0);
            run_txn(d, r, h, {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
